// File: rtl/sram_tc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_tc_pkg
// Description : Shared types and constants for the SRAM test-chip sequencer:
//               packet/result widths, command field map, FSM state encoding
//               and the parity-error result pattern.
//               Optional feature macro: SCAN_PARITY_EN (56-bit packet with
//               odd parity in bit 55).
// Revision    : 1.0 - initial release
// ============================================================================
package sram_tc_pkg;

`ifdef SCAN_PARITY_EN
  localparam int PACKET_W = 56;
  localparam int PAR_BIT  = 55;
`else
  localparam int PACKET_W = 55;
`endif
  localparam int RESULT_W = 64;

  // Command field map (identical in both packet variants)
  localparam int SEL_BIT     = 54;
  localparam int WR_BIT      = 53;
  localparam int WMASK_MSB   = 52;
  localparam int WMASK_LSB   = 49;
  localparam int ADDR_MSB    = 48;
  localparam int ADDR_LSB    = 41;
  localparam int WDATA_MSB   = 40;
  localparam int WDATA_LSB   = 9;
  localparam int RO_EN_BIT   = 8;
  localparam int RO_ADDR_MSB = 7;
  localparam int RO_ADDR_LSB = 0;

  localparam logic [RESULT_W-1:0] PARITY_ERR_RESULT = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic        sel;
    logic        wr;
    logic [3:0]  wmask;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ro_en;
    logic [7:0]  ro_addr;
  } cmd_t;

  // Split a raw packet into its command fields
  function automatic cmd_t decode_cmd(input logic [PACKET_W-1:0] p);
    cmd_t c;
    c.sel     = p[SEL_BIT];
    c.wr      = p[WR_BIT];
    c.wmask   = p[WMASK_MSB:WMASK_LSB];
    c.addr    = p[ADDR_MSB:ADDR_LSB];
    c.wdata   = p[WDATA_MSB:WDATA_LSB];
    c.ro_en   = p[RO_EN_BIT];
    c.ro_addr = p[RO_ADDR_MSB:RO_ADDR_LSB];
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_tc_scan_chain.sv
`default_nettype none
// ============================================================================
// Module      : sram_tc_scan_chain
// Description : Packet-in / result-out shift registers sharing one scan pin
//               pair. Shifting is only allowed while the sequencer is idle;
//               a shift attempt while busy is dropped and flagged sticky.
//               Optional feature macro: SCAN_PARITY_EN (widens the packet).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_tc_scan_chain
  import sram_tc_pkg::*;
(
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                scan_en,
  input  logic                scan_in,
  input  logic                idle,
  input  logic                res_load,
  input  logic [RESULT_W-1:0] res_load_data,
  output logic [PACKET_W-1:0] pkt,
  output logic                scan_out,
  output logic                scan_err
);

  logic [PACKET_W-1:0] pkt_q, pkt_d;
  logic [RESULT_W-1:0] res_q, res_d;
  logic                scan_err_q, scan_err_d;
  logic                shift;

  assign shift    = scan_en & idle;
  assign pkt      = pkt_q;
  assign scan_out = res_q[RESULT_W-1];
  assign scan_err = scan_err_q;

  // Next-state: shift both chains together; a capture load overrides the shift
  always_comb begin
    pkt_d      = pkt_q;
    res_d      = res_q;
    scan_err_d = scan_err_q | (scan_en & ~idle);
    if (shift) begin
      pkt_d = {pkt_q[PACKET_W-2:0], scan_in};
      res_d = {res_q[RESULT_W-2:0], 1'b0};
    end
    if (res_load) begin
      res_d = res_load_data;
    end
  end

  // Scan registers, cleared by async reset so no partial result survives
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q      <= '0;
      res_q      <= '0;
      scan_err_q <= 1'b0;
    end else begin
      pkt_q      <= pkt_d;
      res_q      <= res_d;
      scan_err_q <= scan_err_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_tc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sram_tc_sequencer
// Description : Test-chip controller for two 32x256 SRAM macros. A serially
//               loaded command issues one RW-port access (plus an optional
//               RO-port read) on the selected macro, waits READ_LAT cycles and
//               captures both read ports into the scan result register.
//               Optional feature macro: SCAN_PARITY_EN (packet parity check,
//               extra parity_err output).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_tc_sequencer
  import sram_tc_pkg::*;
#(
  parameter int READ_LAT = 1  // legal range 1..4
)(
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        scan_en,
  input  logic        scan_in,
  output logic        scan_out,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        scan_err,
`ifdef SCAN_PARITY_EN
  output logic        parity_err,
`endif
  output logic [1:0]  sram_csb0,
  output logic [1:0]  sram_web0,
  output logic [7:0]  sram_wmask0,
  output logic [15:0] sram_addr0,
  output logic [63:0] sram_din0,
  input  logic [63:0] sram_dout0,
  output logic [1:0]  sram_csb1,
  output logic [15:0] sram_addr1,
  input  logic [63:0] sram_dout1
);

  localparam int CNT_W = 3;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PACKET_W-1:0] pkt;
  cmd_t                cmd;
  logic                res_load;
  logic [RESULT_W-1:0] res_load_data;
  logic [31:0]         rw_rdata;
  logic [31:0]         ro_rdata;
  logic                go_accept;

  assign cmd       = decode_cmd(pkt);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign go_accept = go & ~scan_en;
  assign rw_rdata  = cmd.sel ? sram_dout0[63:32] : sram_dout0[31:0];
  assign ro_rdata  = cmd.sel ? sram_dout1[63:32] : sram_dout1[31:0];

  sram_tc_scan_chain u_scan (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .scan_en       (scan_en),
    .scan_in       (scan_in),
    .idle          (state_q == ST_IDLE),
    .res_load      (res_load),
    .res_load_data (res_load_data),
    .pkt           (pkt),
    .scan_out      (scan_out),
    .scan_err      (scan_err)
  );

`ifdef SCAN_PARITY_EN
  logic parity_err_q, parity_err_d;
  logic pkt_par_ok;

  // Odd parity: the full 56-bit packet must carry an odd number of ones
  assign pkt_par_ok = ^pkt;
  assign parity_err = parity_err_q;
`endif

  // FSM next state, wait counter and result capture
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    res_load      = 1'b0;
    res_load_data = '0;
`ifdef SCAN_PARITY_EN
    parity_err_d  = parity_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (go_accept) begin
`ifdef SCAN_PARITY_EN
          if (pkt_par_ok) begin
            state_d      = ST_ISSUE;
            parity_err_d = 1'b0;
          end else begin
            // Bad packet never touches the macros; report the marker pattern
            state_d       = ST_DONE;
            parity_err_d  = 1'b1;
            res_load      = 1'b1;
            res_load_data = PARITY_ERR_RESULT;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        if (READ_LAT <= 1) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(READ_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        res_load      = 1'b1;
        res_load_data = {(cmd.wr ? 32'h0 : rw_rdata),
                         (cmd.ro_en ? ro_rdata : 32'h0)};
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; async reset drops every chip select immediately
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SCAN_PARITY_EN
  // Sticky parity error, cleared by the next accepted good packet
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
`endif

  // Macro pin drive: only the ISSUE cycle asserts anything, and only on the selected slice
  always_comb begin
    sram_csb0   = 2'b11;
    sram_web0   = 2'b11;
    sram_csb1   = 2'b11;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    sram_addr1  = '0;
    if (state_q == ST_ISSUE) begin
      if (cmd.sel) begin
        sram_csb0[1]       = 1'b0;
        sram_web0[1]       = ~cmd.wr;
        sram_wmask0[7:4]   = cmd.wmask;
        sram_addr0[15:8]   = cmd.addr;
        sram_din0[63:32]   = cmd.wdata;
        if (cmd.ro_en) begin
          sram_csb1[1]     = 1'b0;
          sram_addr1[15:8] = cmd.ro_addr;
        end
      end else begin
        sram_csb0[0]       = 1'b0;
        sram_web0[0]       = ~cmd.wr;
        sram_wmask0[3:0]   = cmd.wmask;
        sram_addr0[7:0]    = cmd.addr;
        sram_din0[31:0]    = cmd.wdata;
        if (cmd.ro_en) begin
          sram_csb1[0]     = 1'b0;
          sram_addr1[7:0]  = cmd.ro_addr;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_tc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sram_tc_sequencer
// Description : Scoreboard bench for sram_tc_sequencer with pin-level SRAM
//               macro models and a word-level reference memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_tc_sequencer;

  localparam int LAT = 3;

  logic        clk_in  = 1'b0;
  logic        reset_n = 1'b0;
  logic        scan_en = 1'b0;
  logic        scan_in = 1'b0;
  logic        go      = 1'b0;
  logic        mem_clear = 1'b1;
  logic        scan_out, busy, done, scan_err;
  logic [1:0]  sram_csb0, sram_web0, sram_csb1;
  logic [7:0]  sram_wmask0;
  logic [15:0] sram_addr0, sram_addr1;
  logic [63:0] sram_din0, sram_dout0, sram_dout1;

  sram_tc_sequencer #(.READ_LAT(LAT)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .scan_err    (scan_err),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (sram_dout1)
  );

  always #5 clk_in = ~clk_in;

  // Pin-level macro models: data appears exactly LAT cycles after the access edge, junk otherwise
  logic [31:0] smem    [2][256];
  logic [31:0] rw_pipe [2][LAT];
  logic [31:0] ro_pipe [2][LAT];

  always @(posedge clk_in) begin
    for (int m = 0; m < 2; m++) begin
      if (mem_clear) begin
        for (int a = 0; a < 256; a++) smem[m][a] <= 32'h0;
      end else if (!sram_csb0[m] && !sram_web0[m]) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_wmask0[m*4+b])
            smem[m][sram_addr0[m*8+:8]][b*8+:8] <= sram_din0[m*32+b*8+:8];
        end
      end
      rw_pipe[m][0] <= $urandom;
      ro_pipe[m][0] <= $urandom;
      if (!sram_csb0[m] && sram_web0[m]) rw_pipe[m][0] <= smem[m][sram_addr0[m*8+:8]];
      if (!sram_csb1[m]) ro_pipe[m][0] <= smem[m][sram_addr1[m*8+:8]];
      for (int k = 1; k < LAT; k++) begin
        rw_pipe[m][k] <= rw_pipe[m][k-1];
        ro_pipe[m][k] <= ro_pipe[m][k-1];
      end
    end
  end

  assign sram_dout0 = {rw_pipe[1][LAT-1], rw_pipe[0][LAT-1]};
  assign sram_dout1 = {ro_pipe[1][LAT-1], ro_pipe[0][LAT-1]};

  wire [109:0] pins_act = {sram_csb0, sram_web0, sram_csb1, sram_wmask0,
                           sram_addr0, sram_din0, sram_addr1};

  int ntot = 0;
  int nbad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] rmem [2][256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected macro pins during the ISSUE cycle of packet p
  function automatic logic [109:0] pins_exp(input logic [54:0] p);
    logic        s  = p[54];
    logic        wr = p[53];
    logic [3:0]  wm = p[52:49];
    logic [7:0]  a  = p[48:41];
    logic [31:0] wd = p[40:9];
    logic        ro = p[8];
    logic [7:0]  ra = p[7:0];
    logic [1:0]  cs = s ? 2'b01 : 2'b10;
    return {cs, (wr ? cs : 2'b11), (ro ? cs : 2'b11),
            (s ? {wm, 4'h0} : {4'h0, wm}),
            (s ? {a, 8'h0} : {8'h0, a}),
            (s ? {wd, 32'h0} : {32'h0, wd}),
            (ro ? (s ? {ra, 8'h0} : {8'h0, ra}) : 16'h0)};
  endfunction

  // Reference result of packet p, then apply its write to the reference memory
  function automatic logic [63:0] ref_access(input logic [54:0] p);
    int          s  = int'(p[54]);
    logic [31:0] hi = p[53] ? 32'h0 : rmem[s][p[48:41]];
    logic [31:0] lo = p[8] ? rmem[s][p[7:0]] : 32'h0;
    if (p[53]) begin
      for (int b = 0; b < 4; b++)
        if (p[49+b]) rmem[s][p[48:41]][b*8+:8] = p[9+b*8+:8];
    end
    return {hi, lo};
  endfunction

  // Unload 64 result bits while loading the next packet into the tail
  task automatic shift_io(input logic [54:0] p);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      scan_en = 1'b1;
      scan_in = (i < 9) ? 1'($urandom) : p[63-i];
    end
    @(negedge clk_in);
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  // Launch the loaded packet, check ISSUE pins, done latency and quiet pins afterwards
  task automatic run_op(input logic [54:0] p, input bit push, input bit collide);
    logic [63:0] e;
    int   n;
    bit   seen;
    bit   csb_bad;
    @(negedge clk_in);
    go = 1'b1;
    @(negedge clk_in);
    go = 1'b0;
    chk("issue_pins", 128'(pins_act), 128'(pins_exp(p)));
    e = ref_access(p);
    if (push) exp_q.push_back(e);
    n = 0; seen = 1'b0; csb_bad = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk_in);
      n++;
      if (collide && n == 1) begin scan_en = 1'b1; scan_in = 1'($urandom); end
      if (collide && n == 2) scan_en = 1'b0;
      if (sram_csb0 != 2'b11 || sram_csb1 != 2'b11) csb_bad = 1'b1;
      if (done) seen = 1'b1;
    end
    chk("done_latency", 128'(n), 128'(LAT + 1));
    chk("csb_quiet_after_issue", 128'(csb_bad), 128'(0));
    @(negedge clk_in);
    chk("done_single_pulse", 128'({done, busy}), 128'(0));
  endtask

  // Monitor: collect unloaded result bits and compare against the scoreboard
  initial begin : monitor
    logic [63:0] got;
    int nb;
    got = '0;
    nb  = 0;
    forever begin
      @(negedge clk_in);
      #1;
      if (scan_en && !busy && exp_q.size() > 0) begin
        got = {got[62:0], scan_out};
        nb++;
        if (nb == 64) begin
          chk("result", 128'(got), 128'(exp_q.pop_front()));
          nb = 0;
        end
      end
    end
  end

  initial begin : stim
    logic [54:0] p;
    logic [54:0] rd0;
    int w;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 256; a++) rmem[m][a] = 32'h0;

    repeat (3) @(negedge clk_in);
    chk("reset_pins", 128'(pins_act), 128'({6'b111111, 104'h0}));
    chk("reset_flags", 128'({busy, done, scan_err, scan_out}), 128'(0));
    reset_n   = 1'b1;
    mem_clear = 1'b0;

    // Directed: write then read back on macro0
    rd0 = {1'b0, 1'b0, 4'h0, 8'h05, 32'h0, 1'b1, 8'h05};
    shift_io({1'b0, 1'b1, 4'hF, 8'h05, 32'hA5A5_1234, 1'b0, 8'h00});
    run_op({1'b0, 1'b1, 4'hF, 8'h05, 32'hA5A5_1234, 1'b0, 8'h00}, 1'b1, 1'b0);
    shift_io(rd0);
    run_op(rd0, 1'b1, 1'b0);
    // Macro1 isolation
    p = {1'b1, 1'b1, 4'hF, 8'h05, 32'h0000_00FF, 1'b0, 8'h00};
    shift_io(p);
    run_op(p, 1'b1, 1'b0);
    shift_io(rd0);
    run_op(rd0, 1'b1, 1'b0);
    // Byte mask
    p = {1'b0, 1'b1, 4'b0001, 8'h05, 32'hFFFF_FFFF, 1'b0, 8'h00};
    shift_io(p);
    run_op(p, 1'b1, 1'b0);
    shift_io(rd0);
    run_op(rd0, 1'b1, 1'b0);

    // Randomized traffic over a small address window to force hits
    for (int i = 0; i < 40; i++) begin
      w = int'($urandom_range(0, 1));
      p = {1'($urandom), 1'(w), 4'($urandom), 8'($urandom_range(0, 15)),
           32'($urandom), 1'($urandom), 8'($urandom_range(0, 15))};
      shift_io(p);
      run_op(p, 1'b1, 1'b0);
    end

    // Busy collision: shift attempt during WAIT is dropped, packet replays unchanged
    p = {1'b1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b1, 8'h05};
    shift_io(p);
    run_op(p, 1'b0, 1'b1);
    chk("scan_err_set", 128'(scan_err), 128'(1));
    run_op(p, 1'b1, 1'b0);
    chk("scan_err_sticky", 128'(scan_err), 128'(1));

    // Reset during ISSUE: pins drop without a clock edge, no write lands
    p = {1'b0, 1'b1, 4'hF, 8'h05, 32'h1111_2222, 1'b0, 8'h00};
    shift_io(p);
    @(negedge clk_in);
    go = 1'b1;
    @(negedge clk_in);
    go = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk("async_reset_pins", 128'({sram_csb0, sram_csb1, busy, done}), 128'(6'b111100));
    @(negedge clk_in);
    @(negedge clk_in);
    reset_n = 1'b1;
    @(negedge clk_in);
    chk("reset_clears_scan_err", 128'({scan_err, busy}), 128'(0));
    exp_q.push_back(64'h0);
    shift_io(rd0);
    run_op(rd0, 1'b1, 1'b0);
    shift_io(55'h0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_in);
    if (exp_q.size() > 0) begin
      ntot++;
      nbad++;
      $display("FAIL drain: %0d results never unloaded, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $display("test done: total=%0d bad=%0d", ntot, nbad + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sram_tc_sequencer.md
Name: sram_tc_sequencer

Overview:
- Test-chip controller that sequences the two sky130 1 KB (32x256) SRAM macros from a slow serial interface.
- Shifts in a 55-bit command packet, issues one access on the selected macro, waits the read latency, and captures RW-port and RO-port read data.
- Read data shifts back out on the same scan pins.
- Sits between the chip pads/logic analyser and the SRAM macro pins.
- Sole driver of every macro control pin.

Parameters:
- PACKET_W, 55, command packet width; fixed field map below.
- RESULT_W, 64, capture register width: {rw_rdata[31:0], ro_rdata[31:0]}.
- READ_LAT, 1, clk_in cycles from the access edge to valid dout; legal range 1..4.

Ports:
- clk_in  input  1  single clock; also drives clk0/clk1 of both macros.
- reset_n  input  1  asynchronous, active-low reset.
- scan_en  input  1  shift enable for packet-in and result-out.
- scan_in  input  1  serial packet data, MSB first.
- scan_out  output  1  serial result data, MSB first.
- go  input  1  start request; level-sampled.
- busy  output  1  high from go accept until the done cycle (inclusive).
- done  output  1  one-cycle pulse when result is captured.
- scan_err  output  1  sticky: scan_en asserted while busy.
- sram_csb0  output  2  RW chip select per macro, active-low; index = macro.
- sram_web0  output  2  RW write enable per macro, active-low.
- sram_wmask0  output  8  {mask1[3:0], mask0[3:0]}.
- sram_addr0  output  16  {addr1, addr0}.
- sram_din0  output  64  {din1, din0}.
- sram_dout0  input  64  {dout1, dout0}, RW port read data.
- sram_csb1  output  2  RO chip select per macro, active-low.
- sram_addr1  output  16  {raddr1, raddr0}.
- sram_dout1  input  64  RO port read data.

Behaviour:
- Packet fields:
  - [54] sel (0 = macro0, 1 = macro1)
  - [53] wr (1 = write)
  - [52:49] wmask
  - [48:41] addr
  - [40:9] wdata
  - [8] ro_en
  - [7:0] ro_addr
- Reset (async assert, sync-released internally by the first clk_in edge after deassert):
  - state = IDLE.
  - csb0/csb1 = 2'b11; web0 = 2'b11.
  - wmask, addr, din, ro addr = 0.
  - packet and result registers = 0.
  - scan_out = 0; busy = 0; done = 0; scan_err = 0.
- Scan, IDLE only, scan_en = 1:
  - Each edge: pkt <= {pkt[53:0], scan_in} and res <= {res[62:0], 1'b0}.
  - scan_out = res[63] (combinational from register).
  - 55 edges load a packet; 64 edges unload the result. Extra edges keep shifting; no wrap.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
  - IDLE -> ISSUE: go = 1 and scan_en = 0. If go and scan_en are both high, scan wins and go is ignored that cycle.
  - ISSUE (1 cycle):
    - csb0[sel] = 0; web0[sel] = ~wr; wmask/addr/din are driven into the sel slice only.
    - If ro_en: csb1[sel] = 0 and ro_addr is driven.
    - Unselected macro: all csb high.
    - Macros sample on the clk_in edge that leaves ISSUE.
  - WAIT: READ_LAT-1 cycles (skipped when READ_LAT = 1). Counter counts down from READ_LAT-1. All csb high.
  - CAPTURE (1 cycle):
    - res[63:32] = wr ? 32'h0 : sram_dout0[sel slice].
    - res[31:0] = ro_en ? sram_dout1[sel slice] : 32'h0.
  - DONE: done = 1 for one cycle, then IDLE.
- busy = (state != IDLE).
- go held high re-triggers the same packet after DONE. Software drops go before done + 1.
- scan_en while busy: shift is suppressed, scan_err is set, and the packet is untouched. scan_err clears only on reset.
- RW write and RO read of the same address in one ISSUE is legal. RO data is macro-defined, and the controller captures it without interpretation.
- Reset mid-operation: all csb deassert immediately (async); no partial result is retained.

Optional Feature:
- SCAN_PARITY_EN
  - Defined:
    - Packet is 56 bits; bit [55] is odd parity over [54:0], shifted in first.
    - On go, bad parity: ISSUE/WAIT/CAPTURE are skipped (no csb asserted). The FSM goes IDLE -> DONE, and res = 64'hDEAD_BEEF_DEAD_BEEF.
    - Extra output parity_err (1 bit) is sticky until the next accepted good go.
  - Undefined: 55-bit packet, no parity_err port, no check.

Decomposition:
- Package sram_tc_pkg:
  - PACKET_W, RESULT_W, and the field LSB/MSB localparams.
  - State enum encoding: IDLE = 0, ISSUE = 1, WAIT = 2, CAPTURE = 3, DONE = 4.
  - Parity error pattern constant.
- Sub-module sram_tc_scan_chain: packet and result shift registers, scan_out, scan gating. The FSM, macro pin drive and capture stay in the top.

Test Plan:
- Write/readback, macro0:
  - Stimulus: shift {1'b0, 1'b1, 4'hF, 8'h05, 32'hA5A5_1234, 1'b0, 8'h00}, then go. Next, shift {0, 0, 0, 8'h05, 0, 1'b1, 8'h05} and go.
  - Response: in ISSUE of the write, csb0 = 2'b10, web0 = 2'b10, din0[31:0] = 32'hA5A5_1234. The read's unloaded 64 bits = 64'hA5A5_1234_A5A5_1234.
- Macro1 isolation:
  - Stimulus: write 32'h0000_00FF to macro1 address 8'h05.
  - Response: csb0[0] stays 1 throughout. A macro0 address 8'h05 read still returns 32'hA5A5_1234.
- Byte mask:
  - Stimulus: write 32'hFFFF_FFFF with wmask 4'b0001 over 32'hA5A5_1234.
  - Response: read returns 32'hA5A5_12FF.
- Busy collision:
  - Stimulus: pulse scan_en during WAIT (READ_LAT = 3).
  - Response: scan_err = 1 and stays 1. The packet is unchanged, so re-issuing repeats the original access. done arrives 1 + 2 + 1 = 4 cycles after ISSUE entry.
- Reset mid-op:
  - Stimulus: assert reset_n = 0 during ISSUE.
  - Response: csb0 = csb1 = 2'b11 with no clock edge. busy = 0 and the result is 0 after release.
- Parity (SCAN_PARITY_EN):
  - Stimulus: packet with wrong bit [55], then go.
  - Response: no csb low at any time, done pulses, result 64'hDEAD_BEEF_DEAD_BEEF, parity_err = 1.
